// File: rtl/riscv_ex_mem_pipe_pkg.sv
// EX/MEM boundary bundle type and the widths shared with riscv_configs.v.
// RISCV_EXMEM_SKID_EN selects the two-entry skid build of the register.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RISCV_EXMEM_W
`define RISCV_EXMEM_W (5*`XLEN+21)
`endif

package riscv_ex_mem_pipe_pkg;

    localparam int XLEN_W  = `XLEN;
    localparam int EXMEM_W = `RISCV_EXMEM_W;

    typedef struct packed {
        logic [XLEN_W-1:0] fwd_b;
        logic [XLEN_W-1:0] alu_out;
        logic [XLEN_W-1:0] imm;
        logic [XLEN_W-1:0] pcimm;
        logic [XLEN_W-1:0] pc4;
        logic [2:0]        funct3;
        logic [6:0]        opcode;
        logic [4:0]        rd;
        logic [1:0]        src_rd;
        logic [1:0]        src_pc;
        logic              reg_wr_en;
        logic              mem_wr_en;
    } ex_mem_t;

endpackage

// File: rtl/riscv_ex_mem_pipe_slot.sv
// riscv_pipe_slot: one valid+data pipeline entry.
// Clear beats load; data only loads on a load without clear.
module riscv_pipe_slot #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         ld,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic         vld,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld <= 1'b0;
            q   <= '0;
        end else begin
            if (clr) begin
                vld <= 1'b0;
            end else if (ld) begin
                vld <= 1'b1;
            end
            if (ld && !clr) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/riscv_ex_mem_pipe.sv
// riscv_ex_mem_pipe: EX->MEM boundary register with valid/ready and flush.
// Define RISCV_EXMEM_SKID_EN for a registered o_EX_ready via a skid entry.
module riscv_ex_mem_pipe
    import riscv_ex_mem_pipe_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_flush,
    input  logic              i_EX_valid,
    output logic              o_EX_ready,
    input  logic              i_EX_reg_wr_en,
    input  logic              i_EX_mem_wr_en,
    input  logic [1:0]        i_EX_src_rd,
    input  logic [1:0]        i_EX_src_pc,
    input  logic [2:0]        i_EX_funct3,
    input  logic [6:0]        i_EX_opcode,
    input  logic [4:0]        i_EX_rd,
    input  logic [XLEN_W-1:0] i_EX_fwd_b,
    input  logic [XLEN_W-1:0] i_EX_alu_out,
    input  logic [XLEN_W-1:0] i_EX_imm,
    input  logic [XLEN_W-1:0] i_EX_pcimm,
    input  logic [XLEN_W-1:0] i_EX_pc4,
    output logic              o_MEM_valid,
    input  logic              i_MEM_ready,
    output logic              o_MEM_reg_wr_en,
    output logic              o_MEM_mem_wr_en,
    output logic [1:0]        o_MEM_src_rd,
    output logic [1:0]        o_MEM_src_pc,
    output logic [2:0]        o_MEM_funct3,
    output logic [6:0]        o_MEM_opcode,
    output logic [4:0]        o_MEM_rd,
    output logic [XLEN_W-1:0] o_MEM_fwd_b,
    output logic [XLEN_W-1:0] o_MEM_alu_out,
    output logic [XLEN_W-1:0] o_MEM_imm,
    output logic [XLEN_W-1:0] o_MEM_pcimm,
    output logic [XLEN_W-1:0] o_MEM_pc4,
    output logic              o_MEM_fwd_wr_en
);

    ex_mem_t              ex_bus;
    ex_mem_t              mem_bus;
    logic                 m_vld;
    logic                 m_ld;
    logic                 m_clr;
    logic [EXMEM_W-1:0]   m_d;
    logic [EXMEM_W-1:0]   m_q;
    logic                 acc;
    logic                 cons;

    assign ex_bus = '{
        fwd_b:     i_EX_fwd_b,
        alu_out:   i_EX_alu_out,
        imm:       i_EX_imm,
        pcimm:     i_EX_pcimm,
        pc4:       i_EX_pc4,
        funct3:    i_EX_funct3,
        opcode:    i_EX_opcode,
        rd:        i_EX_rd,
        src_rd:    i_EX_src_rd,
        src_pc:    i_EX_src_pc,
        reg_wr_en: i_EX_reg_wr_en,
        mem_wr_en: i_EX_mem_wr_en
    };

    assign acc  = i_EX_valid & o_EX_ready;
    assign cons = m_vld & i_MEM_ready;

`ifdef RISCV_EXMEM_SKID_EN
    logic               s_vld;
    logic               s_ld;
    logic               s_clr;
    logic [EXMEM_W-1:0] s_q;

    // Skid only fills while the head stalls, so it always drains into main first.
    assign o_EX_ready = ~s_vld;
    assign m_ld  = s_vld ? cons : (acc & (~m_vld | cons));
    assign m_d   = s_vld ? s_q : ex_bus;
    assign m_clr = i_flush | (cons & ~s_vld & ~acc);
    assign s_ld  = acc & m_vld & ~cons;
    assign s_clr = i_flush | (s_vld & cons);

    riscv_pipe_slot #(.W(EXMEM_W)) u_skid (
        .clk  (i_clk),
        .rstn (i_rstn),
        .ld   (s_ld),
        .clr  (s_clr),
        .d    (ex_bus),
        .vld  (s_vld),
        .q    (s_q)
    );
`else
    assign o_EX_ready = ~m_vld | i_MEM_ready;
    assign m_ld  = acc;
    assign m_d   = ex_bus;
    assign m_clr = i_flush | (cons & ~acc);
`endif

    riscv_pipe_slot #(.W(EXMEM_W)) u_main (
        .clk  (i_clk),
        .rstn (i_rstn),
        .ld   (m_ld),
        .clr  (m_clr),
        .d    (m_d),
        .vld  (m_vld),
        .q    (m_q)
    );

    assign mem_bus         = m_q;
    assign o_MEM_valid     = m_vld;
    assign o_MEM_fwd_b     = mem_bus.fwd_b;
    assign o_MEM_alu_out   = mem_bus.alu_out;
    assign o_MEM_imm       = mem_bus.imm;
    assign o_MEM_pcimm     = mem_bus.pcimm;
    assign o_MEM_pc4       = mem_bus.pc4;
    assign o_MEM_funct3    = mem_bus.funct3;
    assign o_MEM_opcode    = mem_bus.opcode;
    assign o_MEM_rd        = mem_bus.rd;
    assign o_MEM_src_rd    = mem_bus.src_rd;
    assign o_MEM_src_pc    = mem_bus.src_pc;
    assign o_MEM_reg_wr_en = mem_bus.reg_wr_en;
    assign o_MEM_mem_wr_en = mem_bus.mem_wr_en;
    assign o_MEM_fwd_wr_en = m_vld & mem_bus.reg_wr_en;

endmodule

// File: tb/tb_riscv_ex_mem_pipe.sv
// Testbench for riscv_ex_mem_pipe: vector table, directed corners, random vs queue model.
// Follows RISCV_EXMEM_SKID_EN to pick the expected depth and ready rule.
module tb_riscv_ex_mem_pipe;
    import riscv_ex_mem_pipe_pkg::*;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        ex_valid;
    logic        mem_ready;
    ex_mem_t     drv;

    logic        ex_ready;
    logic        mem_valid;
    logic        fwd_wr_en;
    ex_mem_t     got;

    int n_run;
    int n_fail;
    ex_mem_t mq[$];

    riscv_ex_mem_pipe dut (
        .i_clk           (clk),
        .i_rstn          (rstn),
        .i_flush         (flush),
        .i_EX_valid      (ex_valid),
        .o_EX_ready      (ex_ready),
        .i_EX_reg_wr_en  (drv.reg_wr_en),
        .i_EX_mem_wr_en  (drv.mem_wr_en),
        .i_EX_src_rd     (drv.src_rd),
        .i_EX_src_pc     (drv.src_pc),
        .i_EX_funct3     (drv.funct3),
        .i_EX_opcode     (drv.opcode),
        .i_EX_rd         (drv.rd),
        .i_EX_fwd_b      (drv.fwd_b),
        .i_EX_alu_out    (drv.alu_out),
        .i_EX_imm        (drv.imm),
        .i_EX_pcimm      (drv.pcimm),
        .i_EX_pc4        (drv.pc4),
        .o_MEM_valid     (mem_valid),
        .i_MEM_ready     (mem_ready),
        .o_MEM_reg_wr_en (got.reg_wr_en),
        .o_MEM_mem_wr_en (got.mem_wr_en),
        .o_MEM_src_rd    (got.src_rd),
        .o_MEM_src_pc    (got.src_pc),
        .o_MEM_funct3    (got.funct3),
        .o_MEM_opcode    (got.opcode),
        .o_MEM_rd        (got.rd),
        .o_MEM_fwd_b     (got.fwd_b),
        .o_MEM_alu_out   (got.alu_out),
        .o_MEM_imm       (got.imm),
        .o_MEM_pcimm     (got.pcimm),
        .o_MEM_pc4       (got.pc4),
        .o_MEM_fwd_wr_en (fwd_wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef RISCV_EXMEM_SKID_EN
    localparam int DEPTH = 2;
    localparam bit SKID  = 1'b1;
`else
    localparam int DEPTH = 1;
    localparam bit SKID  = 1'b0;
`endif

    typedef struct {
        bit          rstn;
        bit          flush;
        bit          ex_v;
        bit          mem_r;
        logic [31:0] alu;
        logic [4:0]  rd;
        bit          wr;
        bit          e_v;
        bit          chk_alu;
        logic [31:0] e_alu;
        bit          e_fwd;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        if (SKID) return mq.size() < DEPTH;
        return (mq.size() == 0) || mem_ready;
    endfunction

    function automatic ex_mem_t rnd_bus();
        ex_mem_t b;
        b.fwd_b     = $urandom;
        b.alu_out   = $urandom;
        b.imm       = $urandom;
        b.pcimm     = $urandom;
        b.pc4       = $urandom;
        b.funct3    = 3'($urandom);
        b.opcode    = 7'($urandom);
        b.rd        = 5'($urandom);
        b.src_rd    = 2'($urandom);
        b.src_pc    = 2'($urandom);
        b.reg_wr_en = 1'($urandom);
        b.mem_wr_en = 1'($urandom);
        return b;
    endfunction

    // Advance one clock edge and apply the same edge to the queue model.
    task automatic tick();
        bit rdy;
        rdy = model_ready();
        @(posedge clk);
        if (!rstn || flush) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && mem_ready) void'(mq.pop_front());
            if (ex_valid && rdy) mq.push_back(drv);
        end
        #1;
    endtask

    task automatic check_model(string tag);
        chk({tag, ".ready"}, 256'(ex_ready), 256'(model_ready()));
        chk({tag, ".valid"}, 256'(mem_valid), 256'(mq.size() > 0));
        chk({tag, ".fwd"}, 256'(fwd_wr_en),
            256'(mq.size() > 0 && mq[0].reg_wr_en));
        if (mq.size() > 0)
            chk({tag, ".payload"}, 256'(got), 256'(mq[0]));
    endtask

    initial begin
        n_run     = 0;
        n_fail    = 0;
        rstn      = 1'b0;
        flush     = 1'b0;
        ex_valid  = 1'b0;
        mem_ready = 1'b1;
        drv       = '0;

        tbl[0] = '{0, 0, 0, 1, 32'h00, 5'd0, 0, 0, 1, 32'h00, 0};
        tbl[1] = '{1, 0, 1, 1, 32'h11, 5'd3, 1, 1, 1, 32'h11, 1};
        tbl[2] = '{1, 0, 0, 1, 32'h00, 5'd0, 0, 0, 0, 32'h00, 0};
        tbl[3] = '{1, 0, 1, 0, 32'h22, 5'd4, 0, 1, 1, 32'h22, 0};
        tbl[4] = '{1, 0, 0, 0, 32'h00, 5'd0, 0, 1, 1, 32'h22, 0};
        tbl[5] = '{1, 1, 1, 0, 32'h33, 5'd6, 1, 0, 0, 32'h00, 0};
        tbl[6] = '{1, 0, 1, 1, 32'h44, 5'd7, 1, 1, 1, 32'h44, 1};
        tbl[7] = '{1, 0, 1, 1, 32'h55, 5'd8, 0, 1, 1, 32'h55, 0};
        tbl[8] = '{0, 0, 1, 1, 32'h66, 5'd9, 1, 0, 1, 32'h00, 0};

        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            rstn          = tbl[i].rstn;
            flush         = tbl[i].flush;
            ex_valid      = tbl[i].ex_v;
            mem_ready     = tbl[i].mem_r;
            drv           = '0;
            drv.alu_out   = tbl[i].alu;
            drv.rd        = tbl[i].rd;
            drv.reg_wr_en = tbl[i].wr;
            tick();
            chk($sformatf("vec%0d.valid", i), 256'(mem_valid), 256'(tbl[i].e_v));
            chk($sformatf("vec%0d.fwd", i), 256'(fwd_wr_en), 256'(tbl[i].e_fwd));
            if (tbl[i].chk_alu)
                chk($sformatf("vec%0d.alu", i), 256'(got.alu_out), 256'(tbl[i].e_alu));
            chk($sformatf("vec%0d.ready", i), 256'(ex_ready), 256'(model_ready()));
        end

        // Reset arriving while the head is stalled.
        rstn = 1'b1; flush = 1'b0; mem_ready = 1'b0;
        ex_valid = 1'b1; drv = '0; drv.alu_out = 32'hDEAD_BEEF;
        tick();
        ex_valid = 1'b0;
        tick();
        chk("stall.valid", 256'(mem_valid), 256'(1));
        chk("stall.alu", 256'(got.alu_out), 256'(32'hDEAD_BEEF));
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        #1;
        chk("rst.valid", 256'(mem_valid), 256'(0));
        chk("rst.alu", 256'(got.alu_out), 256'(0));
        chk("rst.ready", 256'(ex_ready), 256'(1));

        // Back-to-back streaming with no bubbles.
        mem_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            ex_valid = 1'b1; drv = '0;
            drv.alu_out = 32'(i); drv.rd = 5'(i);
            tick();
            chk($sformatf("stream%0d.valid", i), 256'(mem_valid), 256'(1));
            chk($sformatf("stream%0d.alu", i), 256'(got.alu_out), 256'(i));
            chk($sformatf("stream%0d.rd", i), 256'(got.rd), 256'(i));
        end
        ex_valid = 1'b0;
        tick();
        chk("stream.drain", 256'(mem_valid), 256'(0));

        // Back-pressure with A, B, C.
        mem_ready = 1'b0; ex_valid = 1'b1; drv = '0; drv.alu_out = 32'h10;
        tick();
        chk("bp.a_alu", 256'(got.alu_out), 256'(32'h10));
        drv.alu_out = 32'h20;
        if (SKID) begin
            chk("bp.a_ready", 256'(ex_ready), 256'(1));
            tick();
            chk("bp.b_ready", 256'(ex_ready), 256'(0));
            chk("bp.b_head", 256'(got.alu_out), 256'(32'h10));
            drv.alu_out = 32'h30;
            tick();
            chk("bp.c_stall", 256'(got.alu_out), 256'(32'h10));
            mem_ready = 1'b1;
            #1;
            chk("bp.ready_reg", 256'(ex_ready), 256'(0));
            tick();
            chk("bp.b_out", 256'(got.alu_out), 256'(32'h20));
            chk("bp.ready_back", 256'(ex_ready), 256'(1));
            tick();
            chk("bp.c_out", 256'(got.alu_out), 256'(32'h30));
        end else begin
            #1;
            chk("bp.b_refused", 256'(ex_ready), 256'(0));
            mem_ready = 1'b1;
            #1;
            chk("bp.ready_comb", 256'(ex_ready), 256'(1));
            mem_ready = 1'b0;
            #1;
            tick();
            chk("bp.a_held", 256'(got.alu_out), 256'(32'h10));
            mem_ready = 1'b1;
            tick();
            chk("bp.b_out", 256'(got.alu_out), 256'(32'h20));
        end
        ex_valid = 1'b0;
        tick();
        chk("bp.drain", 256'(mem_valid), 256'(0));

        // Forwarding qualifier across a flush.
        mem_ready = 1'b0; ex_valid = 1'b1;
        drv = '0; drv.reg_wr_en = 1'b1; drv.rd = 5'd5;
        tick();
        ex_valid = 1'b0;
        chk("fwd.on", 256'(fwd_wr_en), 256'(1));
        tick();
        chk("fwd.hold", 256'(fwd_wr_en), 256'(1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fwd.off", 256'(fwd_wr_en), 256'(0));
        chk("fwd.ready", 256'(ex_ready), 256'(1));

        // Random traffic against the queue model.
        for (int c = 0; c < 600; c++) begin
            rstn      = ($urandom_range(63) != 0);
            flush     = ($urandom_range(15) == 0);
            ex_valid  = 1'($urandom);
            mem_ready = ($urandom_range(3) != 0);
            drv       = rnd_bus();
            #1;
            check_model($sformatf("rnd%0d", c));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
